// File: rtl/wb_timer_pkg.sv
// Shared definitions for the Wishbone timer: register map, CTRL/STATUS bit
// positions, slave handshake states and a byte-lane merge helper.
package wb_timer_pkg;

  localparam logic [9:0] ADR_CTRL    = 10'd0;
  localparam logic [9:0] ADR_PRESC   = 10'd1;
  localparam logic [9:0] ADR_COUNT   = 10'd2;
  localparam logic [9:0] ADR_COMPARE = 10'd3;
  localparam logic [9:0] ADR_STATUS  = 10'd4;
  localparam logic [9:0] ADR_CYCLE   = 10'd5;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_IRQ_EN     = 1;
  localparam int CTRL_AUTORELOAD = 2;
  localparam int CTRL_W          = 3;
  localparam int STATUS_MATCH    = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } wb_state_e;

  // Replace the bytes of cur selected by sel with the matching bytes of wdat.
  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = wdat[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/wb_slave_if.sv
// Wishbone slave handshake: one ack per request assertion, read data captured
// on the same edge that commits the access strobe.
module wb_slave_if
  import wb_timer_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [9:0]  i_adr,
  input  logic [31:0] i_dat,
  input  logic [3:0]  i_sel,
  input  logic [31:0] i_rdata,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_dat,
  output logic        o_acc,
  output logic        o_acc_we,
  output logic [9:0]  o_acc_adr,
  output logic [31:0] o_acc_dat,
  output logic [3:0]  o_acc_sel
);

  wb_state_e state;

  // The strobe fires in the cycle before ACK so the register write and the
  // read-data capture happen on the same edge; the fields are valid with it.
  assign o_acc     = (state == ST_IDLE) && i_req;
  assign o_acc_we  = i_we;
  assign o_acc_adr = i_adr;
  assign o_acc_dat = i_dat;
  assign o_acc_sel = i_sel;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      o_wb_ack <= 1'b0;
      o_wb_dat <= '0;
    end else begin
      o_wb_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_req) begin
            state    <= ST_ACK;
            o_wb_ack <= 1'b1;
            o_wb_dat <= i_rdata;
          end
        end
        ST_ACK:  state <= i_req ? ST_HOLD : ST_IDLE;
        ST_HOLD: if (!i_req) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/wb_timer.sv
// Prescaled 32-bit timer with compare match, auto-reload, interrupt and a
// free-running cycle counter, behind a Wishbone slave port.
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter int PRESC_WIDTH = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_dev_sel,
  input  logic [9:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_stb,
  input  logic        i_wb_cyc,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_ack,
  output logic        o_irq
);

  logic                   req;
  logic                   acc;
  logic                   acc_we;
  logic [9:0]             acc_adr;
  logic [31:0]            acc_dat;
  logic [3:0]             acc_sel;
  logic [31:0]            rdata;

  logic [CTRL_W-1:0]      ctrl;
  logic [PRESC_WIDTH-1:0] presc;
  logic [PRESC_WIDTH-1:0] pcnt;
  logic [31:0]            count;
  logic [31:0]            compare;
  logic [31:0]            cycle;
  logic                   match;

  logic                   wr;
  logic                   wr_ctrl, wr_presc, wr_count, wr_compare, wr_status;
  logic                   tick;
  logic                   hit;
  logic                   clr_match;

  assign req = i_dev_sel & i_wb_cyc & i_wb_stb;

  wb_slave_if u_slave_if (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_req     (req),
    .i_we      (i_wb_we),
    .i_adr     (i_wb_adr),
    .i_dat     (i_wb_dat),
    .i_sel     (i_wb_sel),
    .i_rdata   (rdata),
    .o_wb_ack  (o_wb_ack),
    .o_wb_dat  (o_wb_dat),
    .o_acc     (acc),
    .o_acc_we  (acc_we),
    .o_acc_adr (acc_adr),
    .o_acc_dat (acc_dat),
    .o_acc_sel (acc_sel)
  );

  assign wr         = acc & acc_we;
  assign wr_ctrl    = wr && (acc_adr == ADR_CTRL);
  assign wr_presc   = wr && (acc_adr == ADR_PRESC);
  assign wr_count   = wr && (acc_adr == ADR_COUNT);
  assign wr_compare = wr && (acc_adr == ADR_COMPARE);
  assign wr_status  = wr && (acc_adr == ADR_STATUS);
  assign clr_match  = wr_status && acc_sel[0] && acc_dat[STATUS_MATCH];

  assign tick = ctrl[CTRL_EN] && (pcnt == presc);
  assign hit  = tick && (count == compare);

  assign o_irq = match & ctrl[CTRL_IRQ_EN];

  always_comb begin
    rdata = '0;
    case (acc_adr)
      ADR_CTRL:    rdata[CTRL_W-1:0]      = ctrl;
      ADR_PRESC:   rdata[PRESC_WIDTH-1:0] = presc;
      ADR_COUNT:   rdata                  = count;
      ADR_COMPARE: rdata                  = compare;
      ADR_STATUS:  rdata[STATUS_MATCH]    = match;
      ADR_CYCLE:   rdata                  = cycle;
      default:     rdata                  = '0;
    endcase
  end

  // Prescaler restarts whenever its period is rewritten so the next tick is
  // always a full new period away.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      pcnt <= '0;
    else if (!ctrl[CTRL_EN] || tick || wr_presc)
      pcnt <= '0;
    else
      pcnt <= pcnt + PRESC_WIDTH'(1);
  end

  // A bus write to COUNT wins over the tick; a match set wins over a clear.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count <= '0;
      match <= 1'b0;
    end else begin
      if (wr_count)
        count <= merge_bytes(count, acc_dat, acc_sel);
      else if (tick)
        count <= (hit && ctrl[CTRL_AUTORELOAD]) ? 32'd0 : count + 32'd1;

      if (hit)
        match <= 1'b1;
      else if (clr_match)
        match <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ctrl    <= '0;
      presc   <= '0;
      compare <= '0;
      cycle   <= '0;
    end else begin
      cycle <= cycle + 32'd1;
      if (wr_ctrl)
        ctrl <= CTRL_W'(merge_bytes(32'(ctrl), acc_dat, acc_sel));
      if (wr_presc)
        presc <= PRESC_WIDTH'(merge_bytes(32'(presc), acc_dat, acc_sel));
      if (wr_compare)
        compare <= merge_bytes(compare, acc_dat, acc_sel);
    end
  end

endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer: a register-level reference model is checked
// against ack/read data/irq every cycle, plus hand-computed literal reads.
module tb_wb_timer;

  localparam int          PW    = 16;
  localparam logic [31:0] PMASK = 32'h0000_FFFF;

  logic        i_clk     = 1'b0;
  logic        i_reset   = 1'b1;
  logic        i_dev_sel = 1'b0;
  logic [9:0]  i_wb_adr  = '0;
  logic [31:0] i_wb_dat  = '0;
  logic        i_wb_we   = 1'b0;
  logic        i_wb_stb  = 1'b0;
  logic        i_wb_cyc  = 1'b0;
  logic [3:0]  i_wb_sel  = '0;
  logic [31:0] o_wb_dat;
  logic        o_wb_ack;
  logic        o_irq;

  int   n_chk  = 0;
  int   n_err  = 0;
  bit   chk_en = 1'b0;
  logic [31:0] last_rd;
  logic [31:0] c1, c2;

  wb_timer #(.PRESC_WIDTH(PW)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_dev_sel (i_dev_sel),
    .i_wb_adr  (i_wb_adr),
    .i_wb_dat  (i_wb_dat),
    .o_wb_dat  (o_wb_dat),
    .i_wb_we   (i_wb_we),
    .i_wb_stb  (i_wb_stb),
    .i_wb_cyc  (i_wb_cyc),
    .i_wb_sel  (i_wb_sel),
    .o_wb_ack  (o_wb_ack),
    .o_irq     (o_irq)
  );

  always #5 i_clk = ~i_clk;

  // Reference model state, register-level view of the timer.
  logic [31:0] m_ctrl = '0, m_presc = '0, m_count = '0, m_cmp = '0;
  logic [31:0] m_cycle = '0, m_pcnt = '0, m_dat = '0;
  logic        m_match = 1'b0, m_req_q = 1'b0, m_ack = 1'b0;

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [9:0] a);
    case (a)
      10'd0:   return m_ctrl;
      10'd1:   return m_presc;
      10'd2:   return m_count;
      10'd3:   return m_cmp;
      10'd4:   return {31'd0, m_match};
      10'd5:   return m_cycle;
      default: return 32'd0;
    endcase
  endfunction

  initial forever begin
    logic req, commit, wr, tick, hit;
    logic [31:0] rdv;
    @(posedge i_clk or posedge i_reset);
    if (i_reset) begin
      m_ctrl = '0; m_presc = '0; m_count = '0; m_cmp = '0; m_cycle = '0;
      m_pcnt = '0; m_dat = '0; m_match = 1'b0; m_req_q = 1'b0; m_ack = 1'b0;
    end else begin
      // One transfer per assertion of req: it commits when req is first seen.
      req     = i_dev_sel & i_wb_cyc & i_wb_stb;
      commit  = req && !m_req_q;
      m_req_q = req;
      rdv     = m_read(i_wb_adr);
      wr      = commit && i_wb_we;
      tick    = m_ctrl[0] && (m_pcnt == m_presc);
      hit     = tick && (m_count == m_cmp);
      m_pcnt  = (!m_ctrl[0] || tick || (wr && i_wb_adr == 10'd1)) ? 32'd0 : m_pcnt + 32'd1;
      if (wr && i_wb_adr == 10'd2) m_count = lanes(m_count, i_wb_dat, i_wb_sel);
      else if (tick)               m_count = (hit && m_ctrl[2]) ? 32'd0 : m_count + 32'd1;
      if (hit) m_match = 1'b1;
      else if (wr && i_wb_adr == 10'd4 && i_wb_sel[0] && i_wb_dat[0]) m_match = 1'b0;
      if (wr && i_wb_adr == 10'd0) m_ctrl  = lanes(m_ctrl, i_wb_dat, i_wb_sel) & 32'h7;
      if (wr && i_wb_adr == 10'd1) m_presc = lanes(m_presc, i_wb_dat, i_wb_sel) & PMASK;
      if (wr && i_wb_adr == 10'd3) m_cmp   = lanes(m_cmp, i_wb_dat, i_wb_sel);
      m_cycle = m_cycle + 32'd1;
      if (commit) m_dat = rdv;
      m_ack = commit;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge i_clk);
    #1;
    if (chk_en) begin
      chk("model_ack", {31'd0, o_wb_ack}, {31'd0, m_ack});
      chk("model_rdata", o_wb_dat, m_dat);
      chk("model_irq", {31'd0, o_irq}, {31'd0, m_match & m_ctrl[1]});
    end
  end

  // Called at a negedge; holds the strobe for 'hold' edges, then idles one cycle.
  task automatic xfer(input logic we, input logic [9:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input int hold);
    i_dev_sel = 1'b1; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    i_wb_we = we; i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel;
    for (int i = 0; i < hold; i++) begin
      @(posedge i_clk); #1;
      if (i == 0) begin
        chk("ack_first", {31'd0, o_wb_ack}, 32'd1);
        last_rd = o_wb_dat;
      end else begin
        chk("ack_once", {31'd0, o_wb_ack}, 32'd0);
      end
      @(negedge i_clk);
    end
    i_dev_sel = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    @(posedge i_clk); #1;
    chk("ack_idle", {31'd0, o_wb_ack}, 32'd0);
    @(negedge i_clk);
  endtask

  task automatic wr(input logic [9:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    xfer(1'b1, adr, dat, sel, 1);
  endtask

  task automatic rd_chk(input string name, input logic [9:0] adr, input logic [31:0] exp);
    xfer(1'b0, adr, 32'd0, 4'hF, 1);
    chk(name, last_rd, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_ack", {31'd0, o_wb_ack}, 32'd0);
    chk("rst_dat", o_wb_dat, 32'd0);
    chk("rst_irq", {31'd0, o_irq}, 32'd0);
    chk_en  = 1'b1;
    i_reset = 1'b0;
    @(negedge i_clk);

    // Single CYCLE read with stb held three edges, then a second read.
    xfer(1'b0, 10'd5, 32'd0, 4'hF, 3);
    c1 = last_rd;
    xfer(1'b0, 10'd5, 32'd0, 4'hF, 1);
    c2 = last_rd;
    chk("cycle_delta", c2 - c1, 32'd4);

    // Request without device select is never acked.
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_dev_sel = 1'b0;
    repeat (2) begin
      @(posedge i_clk); #1;
      chk("no_sel_ack", {31'd0, o_wb_ack}, 32'd0);
    end
    @(negedge i_clk);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    @(negedge i_clk);

    // Byte lanes, sel=0, read-only and unmapped accesses.
    wr(10'd2, 32'h1234_5678, 4'b0010);
    rd_chk("count_lane1", 10'd2, 32'h0000_5600);
    wr(10'd3, 32'hFFFF_FFFF, 4'b0000);
    rd_chk("sel0_ignored", 10'd3, 32'd0);
    wr(10'd5, 32'hDEAD_BEEF, 4'hF);
    wr(10'd6, 32'hFFFF_FFFF, 4'hF);
    rd_chk("unmapped6", 10'd6, 32'd0);
    rd_chk("unmapped3ff", 10'h3FF, 32'd0);
    wr(10'd0, 32'hFFFF_FFF8, 4'hF);
    rd_chk("ctrl_unused", 10'd0, 32'd0);
    wr(10'd1, 32'hABCD_1234, 4'hF);
    rd_chk("presc_width", 10'd1, 32'h0000_1234);

    // PRESC=3, COMPARE=5, EN+AUTORELOAD: match on the 6th tick, 24 cycles after EN.
    wr(10'd2, 32'd0, 4'hF);
    wr(10'd1, 32'd3, 4'hF);
    wr(10'd3, 32'd5, 4'hF);
    wr(10'd0, 32'b101, 4'hF);
    repeat (22) @(negedge i_clk);
    rd_chk("match_before24", 10'd4, 32'd0);
    rd_chk("match_after24", 10'd4, 32'd1);
    rd_chk("count_reload", 10'd2, 32'd0);

    // COUNT wraps from all-ones to zero without matching.
    wr(10'd0, 32'd0, 4'hF);
    wr(10'd4, 32'd1, 4'hF);
    wr(10'd2, 32'hFFFF_FFFF, 4'hF);
    wr(10'd3, 32'h10, 4'hF);
    wr(10'd1, 32'd0, 4'hF);
    wr(10'd0, 32'b001, 4'hF);
    rd_chk("count_wrap", 10'd2, 32'd0);
    rd_chk("wrap_nomatch", 10'd4, 32'd0);
    wr(10'd0, 32'd0, 4'hF);

    // STATUS clear landing on the match tick: match and irq stay set.
    wr(10'd4, 32'd1, 4'hF);
    wr(10'd3, 32'd3, 4'hF);
    wr(10'd2, 32'd0, 4'hF);
    wr(10'd0, 32'b011, 4'hF);
    repeat (2) @(negedge i_clk);
    wr(10'd4, 32'd1, 4'hF);
    chk("irq_kept", {31'd0, o_irq}, 32'd1);
    rd_chk("match_kept", 10'd4, 32'd1);
    wr(10'd0, 32'b010, 4'hF);
    wr(10'd4, 32'd1, 4'hF);
    chk("irq_cleared", {31'd0, o_irq}, 32'd0);
    wr(10'd1, 32'd7, 4'hF);

    // Reset pulse during ACK aborts the transfer and clears everything.
    i_dev_sel = 1'b1; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    i_wb_we = 1'b0; i_wb_adr = 10'd3; i_wb_sel = 4'hF;
    @(posedge i_clk); #1;
    chk("ack_pre_rst", {31'd0, o_wb_ack}, 32'd1);
    #1 i_reset = 1'b1;
    #1;
    chk("ack_abort", {31'd0, o_wb_ack}, 32'd0);
    chk("dat_abort", o_wb_dat, 32'd0);
    @(negedge i_clk);
    i_dev_sel = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    rd_chk("rst_ctrl", 10'd0, 32'd0);
    rd_chk("rst_presc", 10'd1, 32'd0);
    rd_chk("rst_count", 10'd2, 32'd0);
    rd_chk("rst_compare", 10'd3, 32'd0);
    rd_chk("rst_status", 10'd4, 32'd0);

    repeat (2) @(negedge i_clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
